// File: rtl/axi_mem_arbiter.sv
// axi_mem_arbiter: shares one AXI4 port between IFU reads (m0) and LSU reads/writes (m1), one transaction at a time.
// Define AXI_ARB_RR_EN for round-robin between m0 and m1; default is fixed priority m1 write > m1 read > m0 read.
module axi_mem_arbiter #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int ID_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                m0_rd_req,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic [2:0]          m0_size,
  input  logic [7:0]          m0_len,
  output logic [DATA_W-1:0]   m0_rdata,
  output logic                m0_rvalid,
  output logic                m0_done,
  input  logic                m1_rd_req,
  input  logic                m1_wr_req,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic [2:0]          m1_size,
  input  logic [7:0]          m1_len,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m1_wstrb,
  output logic                m1_wready,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic                m1_rvalid,
  output logic                m1_done,
  output logic [1:0]          m1_resp,
  output logic                ar_valid,
  input  logic                ar_ready,
  output logic [ID_W-1:0]     ar_id,
  output logic [ADDR_W-1:0]   ar_addr,
  output logic [7:0]          ar_len,
  output logic [2:0]          ar_size,
  output logic [1:0]          ar_burst,
  input  logic                r_valid,
  output logic                r_ready,
  input  logic [DATA_W-1:0]   r_data,
  input  logic                r_last,
  input  logic [1:0]          r_resp,
  output logic                aw_valid,
  input  logic                aw_ready,
  output logic [ID_W-1:0]     aw_id,
  output logic [ADDR_W-1:0]   aw_addr,
  output logic [7:0]          aw_len,
  output logic [2:0]          aw_size,
  output logic [1:0]          aw_burst,
  output logic                w_valid,
  input  logic                w_ready,
  output logic [DATA_W-1:0]   w_data,
  output logic [DATA_W/8-1:0] w_strb,
  output logic                w_last,
  input  logic                b_valid,
  output logic                b_ready,
  input  logic [1:0]          b_resp
);
  typedef enum logic [2:0] {IDLE, RADDR, RDATA, WADDR, WDATA, WRESP} state_t;
  state_t state, state_n;
  logic grant, m1_any, pick1, start, rd, rdone;
  logic [ADDR_W-1:0] addr_q;
  logic [2:0] size_q;
  logic [7:0] len_q, beat_cnt;
  assign m1_any = m1_rd_req | m1_wr_req;
  assign start = m1_any | m0_rd_req;
`ifdef AXI_ARB_RR_EN
  logic last_grant;
  // on a tie the side that did not finish last wins
  assign pick1 = m1_any & (~m0_rd_req | ~last_grant);
  always_ff @(posedge clk)
    if (rst) last_grant <= 1'b1;
    else if (m0_done | m1_done) last_grant <= grant;
`else
  assign pick1 = m1_any;
`endif
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      grant <= 1'b0;
      addr_q <= '0;
      size_q <= '0;
      len_q <= '0;
      beat_cnt <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && start) begin
        grant <= pick1;
        addr_q <= pick1 ? m1_addr : m0_addr;
        size_q <= pick1 ? m1_size : m0_size;
        len_q <= pick1 ? m1_len : m0_len;
      end
      if (w_valid && w_ready) beat_cnt <= w_last ? '0 : beat_cnt + 8'd1;
    end
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = !start ? IDLE : (pick1 && m1_wr_req) ? WADDR : RADDR;
      RADDR:   state_n = ar_ready ? RDATA : RADDR;
      RDATA:   state_n = (r_valid && r_last) ? IDLE : RDATA;
      WADDR:   state_n = aw_ready ? WDATA : WADDR;
      WDATA:   state_n = (w_ready && w_last) ? WRESP : WDATA;
      WRESP:   state_n = b_valid ? IDLE : WRESP;
      default: state_n = IDLE;
    endcase
  end
  assign rd = state == RDATA;
  assign rdone = rd & r_valid & r_last;
  assign ar_valid = state == RADDR;
  assign ar_id = {{(ID_W-1){1'b0}}, grant};
  assign ar_addr = addr_q;
  assign ar_len = len_q;
  assign ar_size = size_q;
  assign ar_burst = 2'b01;
  assign r_ready = rd;
  assign m0_rvalid = rd & r_valid & ~grant;
  assign m1_rvalid = rd & r_valid & grant;
  assign m0_rdata = rd ? r_data : '0;
  assign m1_rdata = rd ? r_data : '0;
  assign m0_done = rdone & ~grant;
  assign m1_done = (rdone & grant) | (b_ready & b_valid);
  assign m1_resp = b_ready ? b_resp : (rd && grant) ? r_resp : 2'b00;
  assign aw_valid = state == WADDR;
  assign aw_id = {{(ID_W-1){1'b0}}, grant};
  assign aw_addr = addr_q;
  assign aw_len = len_q;
  assign aw_size = size_q;
  assign aw_burst = 2'b01;
  assign w_valid = state == WDATA;
  assign w_data = w_valid ? m1_wdata : '0;
  assign w_strb = w_valid ? m1_wstrb : '0;
  assign w_last = w_valid & (beat_cnt == len_q);
  assign m1_wready = w_valid & w_ready;
  assign b_ready = state == WRESP;
endmodule

// File: tb/tb_axi_mem_arbiter.sv
// tb_axi_mem_arbiter: random-stall AXI slave memory plus reference memory and transaction-order model.
module tb_axi_mem_arbiter;
`ifdef AXI_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  logic m0_rd_req, m0_rvalid, m0_done, m1_rd_req, m1_wr_req, m1_wready, m1_rvalid, m1_done;
  logic [63:0] m0_addr, m1_addr, m0_rdata, m1_rdata, m1_wdata, ar_addr, aw_addr, r_data, w_data;
  logic [2:0] m0_size, m1_size, ar_size, aw_size;
  logic [7:0] m0_len, m1_len, m1_wstrb, ar_len, aw_len, w_strb;
  logic [1:0] m1_resp, ar_burst, aw_burst, r_resp, b_resp;
  logic [3:0] ar_id, aw_id;
  logic ar_valid, ar_ready, r_valid, r_ready, r_last, aw_valid, aw_ready;
  logic w_valid, w_ready, w_last, b_valid, b_ready;
  axi_mem_arbiter dut (
    .clk(clk), .rst(rst),
    .m0_rd_req(m0_rd_req), .m0_addr(m0_addr), .m0_size(m0_size), .m0_len(m0_len),
    .m0_rdata(m0_rdata), .m0_rvalid(m0_rvalid), .m0_done(m0_done),
    .m1_rd_req(m1_rd_req), .m1_wr_req(m1_wr_req), .m1_addr(m1_addr), .m1_size(m1_size),
    .m1_len(m1_len), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_wready(m1_wready),
    .m1_rdata(m1_rdata), .m1_rvalid(m1_rvalid), .m1_done(m1_done), .m1_resp(m1_resp),
    .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_id(ar_id), .ar_addr(ar_addr),
    .ar_len(ar_len), .ar_size(ar_size), .ar_burst(ar_burst),
    .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_last(r_last), .r_resp(r_resp),
    .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_id(aw_id), .aw_addr(aw_addr),
    .aw_len(aw_len), .aw_size(aw_size), .aw_burst(aw_burst),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_strb(w_strb), .w_last(w_last),
    .b_valid(b_valid), .b_ready(b_ready), .b_resp(b_resp)
  );
  typedef struct {bit wr; logic [3:0] id; logic [63:0] addr; logic [7:0] len; logic [2:0] size;} txn_t;
  txn_t slog[$];
  logic [63:0] smem[64], rmem[64], wd[256], last_r0;
  logic [7:0] ws[256];
  logic [63:0] a0, a1;
  logic [7:0] l0, l1;
  logic [2:0] s0, s1;
  bit ar_stall, model_lg;
  int checks, errors;
  function automatic int widx(logic [63:0] a, int b);
    return (int'(a[8:3]) + b) & 63;
  endfunction
  task automatic ref_write(int n);
    for (int i = 0; i < n; i++)
      for (int j = 0; j < 8; j++)
        if (ws[i][j]) rmem[widx(a1, i)][8*j+:8] = wd[i][8*j+:8];
  endtask
  // slave drives at negedge, resolves that cycle's handshakes 2 time units later
  initial begin
    logic [63:0] ra, wa;
    int rb, wb, rl;
    bit ract, bpend;
    ract = 0; bpend = 0; rb = 0; wb = 0; rl = 0; ra = 0; wa = 0;
    ar_ready = 0; aw_ready = 0; w_ready = 0; r_valid = 0; r_data = 0; r_last = 0;
    r_resp = 0; b_valid = 0; b_resp = 0;
    forever begin
      @(negedge clk);
      ar_ready = !ar_stall && $urandom_range(0, 3) != 0;
      aw_ready = $urandom_range(0, 3) != 0;
      w_ready = $urandom_range(0, 3) != 0;
      r_valid = ract && $urandom_range(0, 3) != 0;
      r_data = r_valid ? smem[widx(ra, rb)] : 64'd0;
      r_last = r_valid && rb == rl;
      b_valid = bpend && $urandom_range(0, 1) == 1;
      b_resp = b_valid ? 2'($urandom_range(0, 3)) : 2'd0;
      #2;
      if (rst) begin
        ract = 0; bpend = 0;
      end else begin
        if (ar_valid && ar_ready) begin
          slog.push_back('{1'b0, ar_id, ar_addr, ar_len, ar_size});
          ract = 1; ra = ar_addr; rl = int'(ar_len); rb = 0;
        end
        if (r_valid && r_ready) begin
          rb++;
          if (r_last) ract = 0;
        end
        if (aw_valid && aw_ready) begin
          slog.push_back('{1'b1, aw_id, aw_addr, aw_len, aw_size});
          wa = aw_addr; wb = 0;
        end
        if (w_valid && w_ready) begin
          for (int j = 0; j < 8; j++)
            if (w_strb[j]) smem[widx(wa, wb)][8*j+:8] = w_data[8*j+:8];
          wb++;
          if (w_last) bpend = 1;
        end
        if (b_valid && b_ready) bpend = 0;
      end
    end
  end
  // kinds: 0 = m0 read, 1 = m1 read, 2 = m1 write
  task automatic run(input bit q0, input bit q1r, input bit q1w, input int stall, input int rst_beat);
    bit p0, p1r, p1w, d0, d1r, d1w, adv, e0, e1r, e1w, lg, ok;
    int b0, b1r, b1w, cyc, k, gc, ec;
    int got[$], exp[$];
    p0 = q0; p1r = q1r; p1w = q1w; e0 = q0; e1r = q1r; e1w = q1w;
    d0 = 0; d1r = 0; d1w = 0; adv = 0; b0 = 0; b1r = 0; b1w = 0; cyc = 0; lg = model_lg;
    while (e0 || e1r || e1w) begin
      if (RR && e0 && (e1r || e1w)) k = lg ? 0 : (e1w ? 2 : 1);
      else k = e1w ? 2 : e1r ? 1 : 0;
      exp.push_back(k);
      if (k == 0) e0 = 0; else if (k == 1) e1r = 0; else e1w = 0;
      lg = k != 0;
    end
    slog.delete();
    ar_stall = stall > 0;
    m0_addr = a0; m0_len = l0; m0_size = s0; m1_addr = a1; m1_len = l1; m1_size = s1;
    m1_wdata = wd[0]; m1_wstrb = ws[0];
    m0_rd_req = q0; m1_rd_req = q1r; m1_wr_req = q1w;
    while ((p0 || p1r || p1w) && cyc < 3000) begin
      @(negedge clk);
      if (d0) m0_rd_req = 0;
      if (d1r) m1_rd_req = 0;
      if (d1w) m1_wr_req = 0;
      if (adv) begin m1_wdata = wd[b1w & 255]; m1_wstrb = ws[b1w & 255]; end
      d0 = 0; d1r = 0; d1w = 0; adv = 0;
      #1;
      cyc++;
      if (cyc == 1) begin
        checks++;
        if (exp[0] == 2 ? !(aw_valid && aw_id == 4'd1 && aw_addr == a1 && aw_len == l1 && aw_size == s1 && aw_burst == 2'b01)
                        : !(ar_valid && ar_id == (exp[0] == 1 ? 4'd1 : 4'd0) && ar_burst == 2'b01)) begin
          errors++;
          $display("FAIL first_issue ar_valid=%b ar_id=%0d aw_valid=%b aw_id=%0d expected kind %0d", ar_valid, ar_id, aw_valid, aw_id, exp[0]);
        end
      end
      if (cyc <= stall) begin
        checks++;
        if (!ar_valid || ar_addr !== a0 || ar_len !== l0 || ar_size !== s0 || m0_rvalid) begin
          errors++;
          $display("FAIL ar_stall cyc %0d valid=%b addr=%h len=%0d size=%0d rvalid=%b exp addr=%h len=%0d size=%0d", cyc, ar_valid, ar_addr, ar_len, ar_size, m0_rvalid, a0, l0, s0);
        end
        if (cyc == stall) ar_stall = 0;
      end
      if (m0_rvalid) begin
        checks++;
        if (!p0 || m0_rdata !== rmem[widx(a0, b0)]) begin
          errors++;
          $display("FAIL m0_rdata beat %0d got %h exp %h pending=%b", b0, m0_rdata, rmem[widx(a0, b0)], p0);
        end
        last_r0 = m0_rdata;
        b0++;
      end
      if (m0_done) begin
        checks++;
        if (!p0 || !m0_rvalid || b0 != int'(l0) + 1) begin
          errors++;
          $display("FAIL m0_done beats got %0d exp %0d", b0, int'(l0) + 1);
        end
        got.push_back(0); p0 = 0; d0 = 1;
      end
      if (m1_rvalid) begin
        checks++;
        if (!p1r || m1_rdata !== rmem[widx(a1, b1r)]) begin
          errors++;
          $display("FAIL m1_rdata beat %0d got %h exp %h pending=%b", b1r, m1_rdata, rmem[widx(a1, b1r)], p1r);
        end
        b1r++;
      end
      if (m1_done && m1_rvalid) begin
        checks++;
        if (!p1r || b1r != int'(l1) + 1 || m1_resp !== r_resp) begin
          errors++;
          $display("FAIL m1_rd_done beats got %0d exp %0d resp got %0d exp %0d", b1r, int'(l1) + 1, m1_resp, r_resp);
        end
        got.push_back(1); p1r = 0; d1r = 1;
      end
      if (m1_done && !m1_rvalid) begin
        checks++;
        if (!p1w || b1w != int'(l1) + 1 || m1_resp !== b_resp) begin
          errors++;
          $display("FAIL m1_wr_done beats got %0d exp %0d resp got %0d exp %0d", b1w, int'(l1) + 1, m1_resp, b_resp);
        end
        ref_write(b1w);
        got.push_back(2); p1w = 0; d1w = 1;
      end
      if (m1_wready) begin
        checks++;
        if (!p1w || w_data !== wd[b1w & 255] || w_strb !== ws[b1w & 255] || w_last !== (b1w == int'(l1))) begin
          errors++;
          $display("FAIL w_beat %0d data %h strb %h last %b exp %h %h %b", b1w, w_data, w_strb, w_last, wd[b1w & 255], ws[b1w & 255], b1w == int'(l1));
        end
        b1w++; adv = 1;
        if (b1w == rst_beat) begin
          @(negedge clk);
          rst = 1; m0_rd_req = 0; m1_rd_req = 0; m1_wr_req = 0;
          @(negedge clk);
          rst = 0;
          #1;
          checks++;
          if (ar_valid || aw_valid || w_valid || r_ready || b_ready || m1_wready || m0_done || m1_done) begin
            errors++;
            $display("FAIL rst_mid ar=%b aw=%b w=%b r_ready=%b b_ready=%b wready=%b exp all 0", ar_valid, aw_valid, w_valid, r_ready, b_ready, m1_wready);
          end
          ref_write(b1w);
          model_lg = 1;
          return;
        end
      end
    end
    checks++;
    if (cyc >= 3000) begin
      errors++;
      $display("FAIL timeout pending m0=%b m1r=%b m1w=%b", p0, p1r, p1w);
      @(negedge clk); rst = 1; m0_rd_req = 0; m1_rd_req = 0; m1_wr_req = 0; ar_stall = 0;
      @(negedge clk); rst = 0;
      model_lg = 1;
      return;
    end
    ok = got.size() == exp.size();
    gc = 0; ec = 0;
    foreach (got[i]) gc = gc * 10 + got[i] + 1;
    foreach (exp[i]) begin
      ec = ec * 10 + exp[i] + 1;
      if (i >= got.size() || got[i] != exp[i]) ok = 0;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL order got %0d exp %0d", gc, ec);
    end
    ok = slog.size() == exp.size();
    foreach (exp[i])
      if (i < slog.size())
        if (slog[i].wr != (exp[i] == 2) || slog[i].id != (exp[i] == 0 ? 4'd0 : 4'd1) ||
            slog[i].addr != (exp[i] == 0 ? a0 : a1) || slog[i].len != (exp[i] == 0 ? l0 : l1) ||
            slog[i].size != (exp[i] == 0 ? s0 : s1)) ok = 0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL axi_log entries %0d exp %0d first wr=%b id=%0d addr=%h", slog.size(), exp.size(), slog.size() > 0 ? slog[0].wr : 1'b0, slog.size() > 0 ? slog[0].id : 4'd0, slog.size() > 0 ? slog[0].addr : 64'd0);
    end
    model_lg = lg;
    @(negedge clk);
    m0_rd_req = 0; m1_rd_req = 0; m1_wr_req = 0; ar_stall = 0;
    @(negedge clk);
  endtask
  function automatic logic [63:0] rnd_addr();
    return 64'h8000_0000 + 64'({$urandom_range(0, 63), 3'b000});
  endfunction
  task automatic rnd_data(int n);
    for (int i = 0; i < n; i++) begin
      wd[i] = {$urandom, $urandom};
      ws[i] = 8'($urandom_range(0, 255));
    end
  endtask
  task automatic test_reset;
    repeat (3) @(negedge clk);
    rst = 0;
    #1;
    checks++;
    if (ar_valid || aw_valid || w_valid || r_ready || b_ready || m1_wready) begin
      errors++;
      $display("FAIL reset_valids ar=%b aw=%b w=%b r_ready=%b b_ready=%b wready=%b exp 0", ar_valid, aw_valid, w_valid, r_ready, b_ready, m1_wready);
    end
    checks++;
    if (m0_rvalid || m1_rvalid || m0_done || m1_done || m1_resp !== 2'd0) begin
      errors++;
      $display("FAIL reset_req_side rvalid %b%b done %b%b resp %0d exp 0", m0_rvalid, m1_rvalid, m0_done, m1_done, m1_resp);
    end
    checks++;
    if (ar_addr !== 64'd0 || aw_addr !== 64'd0 || w_data !== 64'd0 || w_strb !== 8'd0 || m0_rdata !== 64'd0 || m1_rdata !== 64'd0 || ar_id !== 4'd0) begin
      errors++;
      $display("FAIL reset_data ar_addr=%h aw_addr=%h w_data=%h m0_rdata=%h exp 0", ar_addr, aw_addr, w_data, m0_rdata);
    end
  endtask
  task automatic test_basic_read;
    a0 = 64'h8000_0000; l0 = 8'd3; s0 = 3'd3;
    run(1, 0, 0, 0, 0);
  endtask
  task automatic test_single_write;
    a1 = 64'h8000_0040; l1 = 8'd0; s1 = 3'd3;
    wd[0] = 64'h1122334455667788; ws[0] = 8'h0F;
    run(0, 0, 1, 0, 0);
    a0 = a1; l0 = 8'd0; s0 = 3'd3;
    run(1, 0, 0, 0, 0);
    checks++;
    if (last_r0[31:0] !== 32'h55667788) begin
      errors++;
      $display("FAIL readback_low got %h exp 55667788", last_r0[31:0]);
    end
  endtask
  task automatic test_arbitration;
    a0 = 64'h8000_0100; l0 = 8'd2; s0 = 3'd3;
    a1 = 64'h8000_0180; l1 = 8'd1; s1 = 3'd3;
    run(1, 1, 0, 0, 0);
  endtask
  task automatic test_rd_wr_together;
    a1 = 64'h8000_0020; l1 = 8'd2; s1 = 3'd3;
    rnd_data(3);
    run(0, 1, 1, 0, 0);
    a0 = 64'h8000_0060; l0 = 8'd1; s0 = 3'd3;
    run(1, 1, 1, 0, 0);
  endtask
  task automatic test_reset_mid_write;
    a1 = 64'h8000_0080; l1 = 8'd7; s1 = 3'd3;
    rnd_data(8);
    run(0, 0, 1, 0, 2);
    a0 = a1; l0 = 8'd7; s0 = 3'd3;
    run(1, 0, 0, 0, 0);
    l1 = 8'd3;
    rnd_data(4);
    run(0, 0, 1, 0, 0);
  endtask
  task automatic test_ar_stall;
    a0 = 64'h8000_00C8; l0 = 8'd1; s0 = 3'd3;
    run(1, 0, 0, 5, 0);
  endtask
  task automatic test_random;
    for (int n = 0; n < 40; n++) begin
      int r;
      r = $urandom_range(1, 7);
      a0 = rnd_addr(); a1 = rnd_addr();
      l0 = 8'($urandom_range(0, 7)); l1 = 8'($urandom_range(0, 7));
      s0 = 3'($urandom_range(0, 3)); s1 = 3'($urandom_range(0, 3));
      rnd_data(8);
      run(r[0], r[1], r[2], 0, 0);
    end
  endtask
  initial begin
    checks = 0; errors = 0; model_lg = 1; ar_stall = 0; last_r0 = 0;
    m0_rd_req = 0; m1_rd_req = 0; m1_wr_req = 0;
    m0_addr = 0; m1_addr = 0; m0_size = 0; m1_size = 0; m0_len = 0; m1_len = 0;
    m1_wdata = 0; m1_wstrb = 0;
    for (int i = 0; i < 64; i++) begin
      smem[i] = {$urandom, $urandom};
      rmem[i] = smem[i];
    end
    test_reset;
    test_basic_read;
    test_single_write;
    test_arbitration;
    test_rd_wr_together;
    test_reset_mid_write;
    test_ar_stall;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
